mem_access_sequencer: RTL

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Arbitrates one single-port, synchronous-read word memory between an
// instruction-fetch requester and a data requester. Data wins ties. Sub-word
// stores are performed as read-modify-write. Every output is driven from a
// register. The read-data outputs show the memory's registered read port
// during their ready cycle and hold that word afterwards.
//
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned half/word
// data accesses. These take a one-cycle ERR response with d_err=1 and do not
// touch memory. When the macro is undefined there is no ERR state and d_err
// is tied low.

module mem_access_sequencer (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_format,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE,
    IF_RD,
    IF_WAIT,
    D_RD,
    D_WAIT,
    D_WR,
    RMW_RD,
    RMW_MRG,
`ifdef MISALIGN_CHECK_EN
    RMW_WR,
    ERR
`else
    RMW_WR
`endif
  } state_e;

  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;

  state_e      state_q, state_d;

  // Request attributes captured when a transaction leaves IDLE.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  fmt_q;

  // Attributes of the transaction being steered this cycle. In IDLE they
  // come straight from the winning requester. Elsewhere they come from the
  // captured copy.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_fmt;
  logic        cur_is_word;

  // Read-data hold registers and the load-data select.
  logic [31:0] if_hold_q;
  logic [31:0] d_hold_q;
  logic        d_rd_q;

  // Next-cycle values of the registered outputs.
  logic        busy_d;
  logic        mem_en_d;
  logic        mem_we_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic        if_ready_d;
  logic        d_ready_d;
  logic        d_rd_d;
  logic [31:0] merged;

`ifdef MISALIGN_CHECK_EN
  logic        d_err_d;
  logic        cur_misaligned;
`endif

  assign cur_addr    = (state_q == IDLE) ? (d_req ? d_addr : if_addr) : addr_q;
  assign cur_wdata   = (state_q == IDLE) ? d_wdata : wdata_q;
  assign cur_fmt     = (state_q == IDLE) ? d_format : fmt_q;
  assign cur_is_word = (cur_fmt != FMT_HALF) && (cur_fmt != FMT_BYTE);

`ifdef MISALIGN_CHECK_EN
  assign cur_misaligned = ((cur_fmt == FMT_HALF) && cur_addr[0]) ||
                          (cur_is_word && (cur_addr[1:0] != 2'b00));
`endif

  // While the data output is in its ready cycle, it shows the memory read
  // port directly. Otherwise it shows the held copy.
  assign if_rdata = if_ready ? mem_rdata : if_hold_q;
  assign d_rdata  = d_rd_q   ? mem_rdata : d_hold_q;

  // Merge the right-aligned store data into the word read back from memory.
  // Both the byte lane and the half lane are selected by the low address bits.
  always_comb begin
    merged = mem_rdata;
    if (fmt_q == FMT_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end
  end

  // State, captured request and output registers. Reset takes effect
  // immediately, so an in-flight write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      fmt_q     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      d_rd_q    <= 1'b0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
`ifdef MISALIGN_CHECK_EN
      d_err     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, whatever order the statements are written in.
      state_q   <= state_d;
      if (state_q == IDLE) begin
        addr_q  <= cur_addr;
        wdata_q <= d_wdata;
        fmt_q   <= d_format;
      end
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ready  <= if_ready_d;
      d_ready   <= d_ready_d;
      d_rd_q    <= d_rd_d;
      if (if_ready) if_hold_q <= mem_rdata;
      if (d_rd_q)   d_hold_q  <= mem_rdata;
`ifdef MISALIGN_CHECK_EN
      d_err     <= d_err_d;
`endif
    end
  end

  // Next-state logic. Data has fixed priority in IDLE. Every path returns
  // to IDLE.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a path that left state_d unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          if (!d_we)            state_d = D_RD;
          else if (cur_is_word) state_d = D_WR;
          else                  state_d = RMW_RD;
`ifdef MISALIGN_CHECK_EN
          if (cur_misaligned)   state_d = ERR;
`endif
        end else if (if_req) begin
          state_d = IF_RD;
        end
      end
      IF_RD:   state_d = IF_WAIT;
      IF_WAIT: state_d = IDLE;
      D_RD:    state_d = D_WAIT;
      D_WAIT:  state_d = IDLE;
      D_WR:    state_d = IDLE;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
`ifdef MISALIGN_CHECK_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode for the state being entered. The result is registered, so
  // each output is valid for exactly the cycle spent in that state.
  always_comb begin
    busy_d      = (state_d != IDLE);
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    d_rd_d      = 1'b0;
`ifdef MISALIGN_CHECK_EN
    d_err_d     = 1'b0;
`endif
    if (state_d != IDLE) mem_addr_d = {cur_addr[31:2], 2'b00};
    case (state_d)
      IF_RD:   mem_en_d = 1'b1;
      IF_WAIT: if_ready_d = 1'b1;
      D_RD:    mem_en_d = 1'b1;
      D_WAIT: begin
        d_ready_d = 1'b1;
        d_rd_d    = 1'b1;
      end
      D_WR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_wdata_d = cur_wdata;
        d_ready_d   = 1'b1;
      end
      RMW_RD:  mem_en_d = 1'b1;
      RMW_WR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_wdata_d = merged;
        d_ready_d   = 1'b1;
      end
`ifdef MISALIGN_CHECK_EN
      ERR: begin
        d_ready_d = 1'b1;
        d_err_d   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef MISALIGN_CHECK_EN
  assign d_err = 1'b0;
`endif

endmodule
